// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two requesters, the arbiter and the register file.
// Carries both valid/ready request channels and the registered write port.
interface rf_wb_arbiter_if;
  logic        req0_valid;
  logic [4:0]  req0_rd;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_rd;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        rf_w_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_rdv;
  logic        busy;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    input  req0_ready, req1_ready,
    input  rf_w_en, rf_rd, rf_rdv, busy
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    output req0_ready, req1_ready,
    output rf_w_en, rf_rd, rf_rdv, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin register-file write-port arbiter with optional x1..x31 clear.
// Define RF_WB_ARB_CLEAR_EN to compile in the post-reset clear sequencer.
module rf_wb_arbiter (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  logic        last_grant;
  logic        run;
  logic        g0;
  logic        g1;
  logic        xfer;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        w_en_q;
  logic [4:0]  rd_q;
  logic [31:0] rdv_q;

`ifdef RF_WB_ARB_CLEAR_EN
  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t     state;
  logic [4:0] clr_idx;

  assign run = (state == RUN);
`else
  assign run = 1'b1;
`endif

  // last_grant=1 means req1 won last, so req0 wins the next tie
  always_comb begin
    g0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    g1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
  end

  assign bus.req0_ready = run && !rst && g0;
  assign bus.req1_ready = run && !rst && g1;

  assign xfer     = bus.req0_ready || bus.req1_ready;
  assign sel_rd   = g1 ? bus.req1_rd   : bus.req0_rd;
  assign sel_data = g1 ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RF_WB_ARB_CLEAR_EN
      state   <= CLEAR;
      clr_idx <= 5'd1;
`endif
      last_grant <= 1'b1;
      w_en_q     <= 1'b0;
      rd_q       <= 5'd0;
      rdv_q      <= 32'd0;
    end
`ifdef RF_WB_ARB_CLEAR_EN
    else if (state == CLEAR) begin
      w_en_q  <= 1'b1;
      rd_q    <= clr_idx;
      rdv_q   <= 32'd0;
      clr_idx <= clr_idx + 5'd1;
      if (clr_idx == 5'd31)
        state <= RUN;
    end
`endif
    else begin
      // x0 writes are accepted but never reach the register file
      w_en_q <= xfer && (sel_rd != 5'd0);
      if (xfer) begin
        rd_q       <= sel_rd;
        rdv_q      <= sel_data;
        last_grant <= g1;
      end
    end
  end

  assign bus.rf_w_en = w_en_q;
  assign bus.rf_rd   = rd_q;
  assign bus.rf_rdv  = rdv_q;
  assign bus.busy    = !run;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and initialisation sequencer for the 32×32 register file. Two writeback sources (req0: ALU writeback, req1: load/memory writeback) share the register file's single write port through valid/ready handshakes with round-robin fairness. After reset, an optional clear sequencer walks x1..x31 and writes zero before any requester is served. Outputs connect directly to the register file's write enable, destination index and write-data inputs.

## Interface
Parameters:
- none; data width fixed at 32 and register index width fixed at 5.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_rd  input  5  requester 0 destination register
- req0_data  input  32  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid  input  1  requester 1 has a write pending
- req1_rd  input  5  requester 1 destination register
- req1_data  input  32  requester 1 write data
- req1_ready  output  1  requester 1 write accepted this cycle
- rf_w_en  output  1  register file write enable (registered)
- rf_rd  output  5  register file destination index (registered)
- rf_rdv  output  32  register file write data (registered)
- busy  output  1  clear sequence in progress

## Operation
- FSM states: CLEAR, RUN.
- CLEAR: 5-bit counter clr_idx issues one write per cycle: rf_w_en=1, rf_rd=clr_idx, rf_rdv=0. clr_idx runs 1..31; the edge that issues index 31 moves the FSM to RUN. Index 0 is never written. busy=1 and both readys=0 throughout CLEAR.
- RUN: busy=0. Grant is combinational from valids and the last_grant flag:
  - only reqN_valid=1 -> grant N
  - both valid -> grant the requester not equal to last_grant
  - neither valid -> no grant
- reqN_ready = (state==RUN) && grant==N; at most one ready is high per cycle. A transfer occurs when valid&&ready.
- On a transfer: rf_w_en<=1, rf_rd<=reqN_rd, rf_rdv<=reqN_data, last_grant<=N.
- Transfer with reqN_rd==0: accepted (ready=1, last_grant updates) but rf_w_en<=0; the write is dropped.
- No transfer in RUN: rf_w_en<=0; rf_rd/rf_rdv hold their previous values.
- Requester rule: once valid is asserted, valid, rd and data stay stable until ready is seen. The arbiter does not check this rule.
- A loser under contention waits exactly one cycle when the other requester does not re-request. Under continuous contention, grants alternate 0,1,0,1.

## Timing
- Reset (any edge with rst=1): state<=CLEAR (RUN when the macro is absent), clr_idx<=1, last_grant<=1 (req0 wins first contention), rf_w_en<=0, rf_rd<=0, rf_rdv<=0. Readys read 0 while rst=1.
- Reset mid-CLEAR or mid-RUN: takes effect on that edge; the clear sequence restarts from x1. An in-flight registered write is discarded.
- Clear length: 31 cycles. Edge k after reset release (k=1..31) drives rf_rd=k. The first cycle with readys possible is the cycle after edge 31.
- Write latency: handshake in cycle n -> rf_w_en high in cycle n+1 (one register stage). Throughput: one write per cycle.
- The register file's write-through bypass covers the rf_* stage. The arbiter adds no forwarding.

## Configuration
- RF_WB_ARB_CLEAR_EN defined: CLEAR state and counter are compiled in; behaviour is as above.
- RF_WB_ARB_CLEAR_EN undefined: no CLEAR state or counter. Reset enters RUN directly, busy is tied to 0, and requests can be accepted in the first cycle after rst deasserts.

## Test plan
- Reset release, macro defined -> rf_w_en=1 for 31 consecutive cycles, rf_rd=1..31, rf_rdv=0, busy=1. busy=0 and req0_ready=1 (req0_valid held) in the following cycle.
- RUN, req0 only (rd=5, data=0xDEADBEEF) -> req0_ready=1 the same cycle; next cycle rf_w_en=1, rf_rd=5, rf_rdv=0xDEADBEEF.
- Both valid for 4 cycles (rd=3/0x11, rd=4/0x22), fresh data after each accept -> grants 0,1,0,1; rf_rd sequence 3,4,3,4.
- req1 with rd=0, data=0x55 -> req1_ready=1; next cycle rf_w_en=0.
- rst pulsed for 1 cycle at clear index 10 -> sequence restarts at rf_rd=1; total 31 clear writes after release.
- Macro undefined, reset release with req1_valid (rd=7, data=0x1) -> req1_ready=1 in the first cycle; rf_rd=7 the next cycle; busy never 1.
